// File: rtl/tvip_axi_types_pkg.sv
// Shared AXI VIP types: burst encodings, field helpers and the
// per-beat address/strobe math used by both RTL and the UVM model.
package tvip_axi_types_pkg;

  localparam int TVIP_AXI_MAX_ADDRESS_WIDTH = 64;
  localparam int TVIP_AXI_MAX_DATA_WIDTH    = 1024;

  typedef logic [TVIP_AXI_MAX_ADDRESS_WIDTH-1:0]   tvip_axi_address;
  typedef logic [TVIP_AXI_MAX_DATA_WIDTH/8-1:0]    tvip_axi_strobe;
  typedef logic [7:0]                              tvip_axi_burst_length;

  typedef enum logic [2:0] {
    TVIP_AXI_BURST_SIZE_1_BYTE    = 3'd0,
    TVIP_AXI_BURST_SIZE_2_BYTES   = 3'd1,
    TVIP_AXI_BURST_SIZE_4_BYTES   = 3'd2,
    TVIP_AXI_BURST_SIZE_8_BYTES   = 3'd3,
    TVIP_AXI_BURST_SIZE_16_BYTES  = 3'd4,
    TVIP_AXI_BURST_SIZE_32_BYTES  = 3'd5,
    TVIP_AXI_BURST_SIZE_64_BYTES  = 3'd6,
    TVIP_AXI_BURST_SIZE_128_BYTES = 3'd7
  } tvip_axi_burst_size;

  typedef enum logic [1:0] {
    TVIP_AXI_FIXED_BURST        = 2'b00,
    TVIP_AXI_INCREMENTING_BURST = 2'b01,
    TVIP_AXI_WRAPPING_BURST     = 2'b10,
    TVIP_AXI_RESERVED_BURST     = 2'b11
  } tvip_axi_burst_type;

  function automatic int unpack_burst_length(
    tvip_axi_burst_length length
  );
    return int'(length) + 1;
  endfunction

  function automatic int unpack_burst_size(
    tvip_axi_burst_size size
  );
    return 1 << size;
  endfunction

  // Address of the beat following addr. The wrap window is derived
  // from addr itself, so it works for any beat inside the window.
  function automatic tvip_axi_address calc_next_address(
    tvip_axi_address      addr,
    tvip_axi_burst_size   size,
    tvip_axi_burst_length length,
    tvip_axi_burst_type   burst_type
  );
    tvip_axi_address s;
    tvip_axi_address w;
    tvip_axi_address lo;
    tvip_axi_address nxt;
    s   = tvip_axi_address'(unpack_burst_size(size));
    w   = s * tvip_axi_address'(unpack_burst_length(length));
    lo  = addr & ~(w - 1);
    nxt = (addr & ~(s - 1)) + s;
    case (burst_type)
      TVIP_AXI_FIXED_BURST:    nxt = addr;
      TVIP_AXI_WRAPPING_BURST: if (nxt == lo + w) nxt = lo;
      default:                 ;
    endcase
    return nxt;
  endfunction

  // Lanes from the (possibly unaligned) byte address up to the end
  // of the aligned transfer container.
  function automatic tvip_axi_strobe calc_strobe(
    tvip_axi_address    addr,
    tvip_axi_burst_size size,
    int                 data_width
  );
    tvip_axi_strobe  strb;
    tvip_axi_address s;
    tvip_axi_address nm;
    tvip_axi_address lo;
    tvip_axi_address hi;
    int              n;
    n    = data_width / 8;
    s    = tvip_axi_address'(unpack_burst_size(size));
    nm   = tvip_axi_address'(n - 1);
    lo   = addr & nm;
    hi   = ((addr & ~(s - 1)) & nm) + s - 1;
    strb = '0;
    for (int i = 0; i < TVIP_AXI_MAX_DATA_WIDTH / 8; i++) begin
      strb[i] = (i < n) &&
                (tvip_axi_address'(i) >= lo) &&
                (tvip_axi_address'(i) <= hi);
    end
    return strb;
  endfunction

  function automatic bit is_legal_burst(
    tvip_axi_burst_size   size,
    tvip_axi_burst_length length,
    tvip_axi_burst_type   burst_type,
    int                   data_width
  );
    bit ok;
    ok = 1'b1;
    if (unpack_burst_size(size) > data_width / 8) ok = 1'b0;
    if (burst_type == TVIP_AXI_RESERVED_BURST) ok = 1'b0;
    if (burst_type == TVIP_AXI_WRAPPING_BURST &&
        !(length inside {8'd1, 8'd3, 8'd7, 8'd15})) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/tvip_axi_burst_address_generator_if.sv
// Command-in / beat-out bundle of the burst address generator.
// master: command source and beat sink; slave: the generator.
interface tvip_axi_burst_address_generator_if #(
  parameter int ID_WIDTH      = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  import tvip_axi_types_pkg::*;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [ID_WIDTH-1:0]       cmd_id;
  logic [ADDRESS_WIDTH-1:0]  cmd_address;
  tvip_axi_burst_length      cmd_burst_length;
  tvip_axi_burst_size        cmd_burst_size;
  tvip_axi_burst_type        cmd_burst_type;
  logic                      cmd_error;

  logic                      beat_valid;
  logic                      beat_ready;
  logic [ID_WIDTH-1:0]       beat_id;
  logic [ADDRESS_WIDTH-1:0]  beat_address;
  logic [7:0]                beat_index;
  logic                      beat_last;
  logic [DATA_WIDTH/8-1:0]   beat_strobe;

  modport master (
    output cmd_valid, cmd_id, cmd_address,
    output cmd_burst_length, cmd_burst_size, cmd_burst_type,
    output beat_ready,
    input  cmd_ready, cmd_error,
    input  beat_valid, beat_id, beat_address,
    input  beat_index, beat_last, beat_strobe
  );

  modport slave (
    input  cmd_valid, cmd_id, cmd_address,
    input  cmd_burst_length, cmd_burst_size, cmd_burst_type,
    input  beat_ready,
    output cmd_ready, cmd_error,
    output beat_valid, beat_id, beat_address,
    output beat_index, beat_last, beat_strobe
  );

endinterface

// File: rtl/tvip_axi_burst_address_generator.sv
// Expands one AXI AW/AR command into per-beat address/strobe/last.
// Ports: aclk, areset_n (async, active-low), bus (slave modport).
module tvip_axi_burst_address_generator
  import tvip_axi_types_pkg::*;
#(
  parameter int ID_WIDTH      = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic aclk,
  input  logic areset_n,
  tvip_axi_burst_address_generator_if.slave bus
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int SIZE_MAX = $clog2(STRB_W);

  typedef enum logic {IDLE, BURST} state_e;

  state_e state_q;
  state_e state_d;

  logic [ID_WIDTH-1:0]      id_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] addr_next;
  logic [7:0]               index_q;
  logic                     last_q;
  logic [STRB_W-1:0]        strobe_q;
  tvip_axi_burst_length     len_q;
  tvip_axi_burst_size       size_q;
  tvip_axi_burst_type       type_q;
  logic                     error_q;

  logic                     legal;
  tvip_axi_burst_size       size_eff;
  tvip_axi_burst_type       type_eff;
  logic                     cmd_fire;
  logic                     beat_fire;

  assign bus.beat_valid   = (state_q == BURST);
  assign beat_fire        = bus.beat_valid & bus.beat_ready;
  // Taking a command on the last-beat handshake avoids a bubble.
  assign bus.cmd_ready    = (state_q == IDLE) | (beat_fire & last_q);
  assign cmd_fire         = bus.cmd_valid & bus.cmd_ready;

  assign bus.beat_id      = id_q;
  assign bus.beat_address = addr_q;
  assign bus.beat_index   = index_q;
  assign bus.beat_last    = last_q;
  assign bus.beat_strobe  = strobe_q;
  assign bus.cmd_error    = error_q;

  // Illegal commands still run, as INCR with size clamped to the bus.
  always_comb begin
    legal    = is_legal_burst(bus.cmd_burst_size, bus.cmd_burst_length,
                              bus.cmd_burst_type, DATA_WIDTH);
    size_eff = bus.cmd_burst_size;
    type_eff = bus.cmd_burst_type;
    if (!legal) begin
      type_eff = TVIP_AXI_INCREMENTING_BURST;
      if (unpack_burst_size(bus.cmd_burst_size) > STRB_W)
        size_eff = tvip_axi_burst_size'(3'(SIZE_MAX));
    end
  end

  assign addr_next = ADDRESS_WIDTH'(calc_next_address(
    tvip_axi_address'(addr_q), size_q, len_q, type_q));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd_fire) state_d = BURST;
      BURST: if (beat_fire && last_q)
               state_d = cmd_fire ? BURST : IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Registered so the pulse lines up with beat 0 of the bad command.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) error_q <= 1'b0;
    else           error_q <= cmd_fire & ~legal;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      id_q     <= '0;
      addr_q   <= '0;
      index_q  <= '0;
      last_q   <= 1'b0;
      strobe_q <= '0;
      len_q    <= '0;
      size_q   <= TVIP_AXI_BURST_SIZE_1_BYTE;
      type_q   <= TVIP_AXI_FIXED_BURST;
    end else if (cmd_fire) begin
      id_q     <= bus.cmd_id;
      addr_q   <= bus.cmd_address;
      index_q  <= '0;
      last_q   <= (bus.cmd_burst_length == 8'd0);
      strobe_q <= STRB_W'(calc_strobe(
                    tvip_axi_address'(bus.cmd_address),
                    size_eff, DATA_WIDTH));
      len_q    <= bus.cmd_burst_length;
      size_q   <= size_eff;
      type_q   <= type_eff;
    end else if (beat_fire && !last_q) begin
      addr_q   <= addr_next;
      index_q  <= index_q + 8'd1;
      last_q   <= (index_q + 8'd1 == len_q);
      strobe_q <= STRB_W'(calc_strobe(
                    tvip_axi_address'(addr_next),
                    size_q, DATA_WIDTH));
    end
  end

endmodule

// File: tb/tb_tvip_axi_burst_address_generator.sv
// Directed bench for the burst address generator: 32-bit bus for
// INCR/FIXED/illegal/reset cases, 64-bit bus for WRAP.
module tb_tvip_axi_burst_address_generator;
  import tvip_axi_types_pkg::*;

  logic aclk     = 1'b0;
  logic areset_n = 1'b1;
  int   n_cmp    = 0;
  int   n_err    = 0;

  always #5 aclk = ~aclk;

  tvip_axi_burst_address_generator_if #(
    .ID_WIDTH(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32)
  ) a ();

  tvip_axi_burst_address_generator_if #(
    .ID_WIDTH(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(64)
  ) b ();

  tvip_axi_burst_address_generator #(
    .ID_WIDTH(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32)
  ) u_dut32 (
    .aclk(aclk), .areset_n(areset_n), .bus(a)
  );

  tvip_axi_burst_address_generator #(
    .ID_WIDTH(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(64)
  ) u_dut64 (
    .aclk(aclk), .areset_n(areset_n), .bus(b)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cmd32(
    input logic [3:0]         id,
    input logic [31:0]        addr,
    input logic [7:0]         len,
    input tvip_axi_burst_size size,
    input tvip_axi_burst_type bt
  );
    @(negedge aclk);
    a.cmd_id           = id;
    a.cmd_address      = addr;
    a.cmd_burst_length = len;
    a.cmd_burst_size   = size;
    a.cmd_burst_type   = bt;
    a.cmd_valid        = 1'b1;
    a.beat_ready       = 1'b1;
    #1 chk("cmd_ready", a.cmd_ready, 1);
  endtask

  task automatic beat32(
    input string      tag,
    input logic [31:0] addr,
    input logic [3:0]  strb,
    input logic [7:0]  idx,
    input logic        last,
    input logic        err,
    input bit          stall
  );
    logic [31:0] held;
    if (stall) begin
      @(negedge aclk);
      a.cmd_valid  = 1'b0;
      a.beat_ready = 1'b0;
      #1;
      chk({tag, ".stall_valid"}, a.beat_valid, 1);
      chk({tag, ".stall_addr"}, a.beat_address, addr);
      chk({tag, ".err"}, a.cmd_error, err);
      held = a.beat_address;
    end
    @(negedge aclk);
    a.cmd_valid  = 1'b0;
    a.beat_ready = 1'b1;
    #1;
    chk({tag, ".valid"}, a.beat_valid, 1);
    chk({tag, ".addr"}, a.beat_address, addr);
    chk({tag, ".strb"}, a.beat_strobe, strb);
    chk({tag, ".idx"}, a.beat_index, idx);
    chk({tag, ".last"}, a.beat_last, last);
    chk({tag, ".rdy"}, a.cmd_ready, last);
    if (stall) chk({tag, ".stable"}, a.beat_address, held);
    else       chk({tag, ".err"}, a.cmd_error, err);
  endtask

  logic [31:0] wexp [4] = '{32'h38, 32'h20, 32'h28, 32'h30};

  initial begin
    a.cmd_valid = 0; a.cmd_id = 0; a.cmd_address = 0;
    a.cmd_burst_length = 0; a.beat_ready = 0;
    a.cmd_burst_size = TVIP_AXI_BURST_SIZE_1_BYTE;
    a.cmd_burst_type = TVIP_AXI_FIXED_BURST;
    b.cmd_valid = 0; b.cmd_id = 0; b.cmd_address = 0;
    b.cmd_burst_length = 0; b.beat_ready = 0;
    b.cmd_burst_size = TVIP_AXI_BURST_SIZE_1_BYTE;
    b.cmd_burst_type = TVIP_AXI_FIXED_BURST;

    #2 areset_n = 1'b0;
    #1;
    chk("rst.ready", a.cmd_ready, 1);
    chk("rst.valid", a.beat_valid, 0);
    chk("rst.err", a.cmd_error, 0);
    chk("rst.addr", a.beat_address, 0);
    chk("rst.strb", a.beat_strobe, 0);
    chk("rst.last", a.beat_last, 0);
    chk("rst.idx", a.beat_index, 0);
    chk("rst.id", a.beat_id, 0);
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;

    // INCR aligned, 4 beats
    cmd32(4'h3, 32'h1000, 8'd3, TVIP_AXI_BURST_SIZE_4_BYTES,
          TVIP_AXI_INCREMENTING_BURST);
    beat32("incr0", 32'h1000, 4'hF, 0, 0, 0, 0);
    chk("incr0.id", a.beat_id, 4'h3);
    beat32("incr1", 32'h1004, 4'hF, 1, 0, 0, 0);
    beat32("incr2", 32'h1008, 4'hF, 2, 0, 0, 0);
    beat32("incr3", 32'h100C, 4'hF, 3, 1, 0, 0);
    @(negedge aclk);
    #1 chk("incr.idle_valid", a.beat_valid, 0);

    // INCR unaligned
    cmd32(4'h1, 32'h1003, 8'd1, TVIP_AXI_BURST_SIZE_4_BYTES,
          TVIP_AXI_INCREMENTING_BURST);
    beat32("ua0", 32'h1003, 4'h8, 0, 0, 0, 0);
    beat32("ua1", 32'h1004, 4'hF, 1, 1, 0, 0);

    // FIXED with stalls
    cmd32(4'h2, 32'h2002, 8'd2, TVIP_AXI_BURST_SIZE_2_BYTES,
          TVIP_AXI_FIXED_BURST);
    beat32("fix0", 32'h2002, 4'hC, 0, 0, 0, 1);
    beat32("fix1", 32'h2002, 4'hC, 1, 0, 0, 1);
    beat32("fix2", 32'h2002, 4'hC, 2, 1, 0, 1);

    // Illegal WRAP (3 beats) then back-to-back command
    cmd32(4'h4, 32'h3000, 8'd2, TVIP_AXI_BURST_SIZE_4_BYTES,
          TVIP_AXI_WRAPPING_BURST);
    beat32("ill0", 32'h3000, 4'hF, 0, 0, 1, 0);
    beat32("ill1", 32'h3004, 4'hF, 1, 0, 0, 0);
    @(negedge aclk);
    a.beat_ready       = 1'b1;
    a.cmd_id           = 4'h5;
    a.cmd_address      = 32'h4000;
    a.cmd_burst_length = 8'd0;
    a.cmd_burst_size   = TVIP_AXI_BURST_SIZE_4_BYTES;
    a.cmd_burst_type   = TVIP_AXI_INCREMENTING_BURST;
    a.cmd_valid        = 1'b1;
    #1;
    chk("ill2.addr", a.beat_address, 32'h3008);
    chk("ill2.last", a.beat_last, 1);
    chk("ill2.rdy", a.cmd_ready, 1);
    beat32("b2b0", 32'h4000, 4'hF, 0, 1, 0, 0);
    chk("b2b0.id", a.beat_id, 4'h5);
    @(negedge aclk);
    #1 chk("b2b.idle_valid", a.beat_valid, 0);

    // Reset during beat 1
    cmd32(4'h6, 32'h5000, 8'd3, TVIP_AXI_BURST_SIZE_4_BYTES,
          TVIP_AXI_INCREMENTING_BURST);
    beat32("rb0", 32'h5000, 4'hF, 0, 0, 0, 0);
    @(negedge aclk);
    a.beat_ready = 1'b0;
    #1 chk("rb1.addr", a.beat_address, 32'h5004);
    areset_n = 1'b0;
    #1;
    chk("mid_rst.valid", a.beat_valid, 0);
    chk("mid_rst.ready", a.cmd_ready, 1);
    chk("mid_rst.addr", a.beat_address, 0);
    chk("mid_rst.idx", a.beat_index, 0);
    chk("mid_rst.strb", a.beat_strobe, 0);
    @(negedge aclk);
    areset_n = 1'b1;
    cmd32(4'h7, 32'h6010, 8'd0, TVIP_AXI_BURST_SIZE_4_BYTES,
          TVIP_AXI_INCREMENTING_BURST);
    beat32("post0", 32'h6010, 4'hF, 0, 1, 0, 0);

    // WRAP on 64-bit bus
    @(negedge aclk);
    b.cmd_id           = 4'h9;
    b.cmd_address      = 32'h38;
    b.cmd_burst_length = 8'd3;
    b.cmd_burst_size   = TVIP_AXI_BURST_SIZE_8_BYTES;
    b.cmd_burst_type   = TVIP_AXI_WRAPPING_BURST;
    b.cmd_valid        = 1'b1;
    b.beat_ready       = 1'b1;
    #1 chk("wrap.ready", b.cmd_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      b.cmd_valid = 1'b0;
      #1;
      chk($sformatf("wrap%0d.valid", k), b.beat_valid, 1);
      chk($sformatf("wrap%0d.addr", k), b.beat_address, wexp[k]);
      chk($sformatf("wrap%0d.strb", k), b.beat_strobe, 8'hFF);
      chk($sformatf("wrap%0d.idx", k), b.beat_index, k);
      chk($sformatf("wrap%0d.last", k), b.beat_last, k == 3);
      chk($sformatf("wrap%0d.err", k), b.cmd_error, 0);
    end
    @(negedge aclk);
    #1 chk("wrap.idle_valid", b.beat_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
